// File: rtl/secuenciador_melodia_pkg.sv
// Shared definitions for the melody sequencer: FSM state encoding, note codes,
// song-table entry layout and small field/decode helpers.
package secuenciador_melodia_pkg;

    localparam int ENTRY_W = 8;
    localparam int DUR_W   = 5;
    localparam int NOTE_W  = 3;
    localparam int KEYS_W  = 7;

    localparam logic [NOTE_W-1:0] NOTA_SIL = 3'd0;
    localparam logic [NOTE_W-1:0] NOTA_DO  = 3'd1;
    localparam logic [NOTE_W-1:0] NOTA_RE  = 3'd2;
    localparam logic [NOTE_W-1:0] NOTA_MI  = 3'd3;
    localparam logic [NOTE_W-1:0] NOTA_FA  = 3'd4;
    localparam logic [NOTE_W-1:0] NOTA_SOL = 3'd5;
    localparam logic [NOTE_W-1:0] NOTA_LA  = 3'd6;
    localparam logic [NOTE_W-1:0] NOTA_SI  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PLAY  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } estado_t;

    // Entry layout: {note[2:0], dur[4:0]}; dur == 0 marks end of song.
    function automatic logic [NOTE_W-1:0] entry_nota(input logic [ENTRY_W-1:0] e);
        return e[ENTRY_W-1 -: NOTE_W];
    endfunction

    function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
        return e[DUR_W-1:0];
    endfunction

    // Rest maps to all keys released; never more than one bit set.
    function automatic logic [KEYS_W-1:0] nota_a_teclas(input logic [NOTE_W-1:0] n);
        logic [KEYS_W-1:0] t;
        t = '0;
        if (n != NOTA_SIL)
            t = KEYS_W'(1) << (n - 3'd1);
        return t;
    endfunction

endpackage

// File: rtl/secuenciador_melodia_rom.sv
// Song table for the melody sequencer.
//   addr  : table index
//   entry : {note[2:0], dur[4:0]}; unlisted addresses read as 8'h00 (end marker)
// USE_CUSTOM replaces the built-in tune with CUSTOM_TABLE (entry i at bits [8i+7:8i]).
module secuenciador_melodia_rom
    import secuenciador_melodia_pkg::*;
#(
    parameter int                          SONG_LEN     = 32,
    parameter int                          ADDR_W       = 5,
    parameter bit                          USE_CUSTOM   = 1'b0,
    parameter logic [SONG_LEN*ENTRY_W-1:0] CUSTOM_TABLE = '0
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [ENTRY_W-1:0] entry
);

    if (USE_CUSTOM) begin : gen_custom
        always_comb entry = CUSTOM_TABLE[int'(addr)*ENTRY_W +: ENTRY_W];
    end else begin : gen_builtin
        // Twinkle twinkle: quarter notes are 4 ticks, halves 8 ticks.
        always_comb begin
            case (int'(addr))
                0:       entry = {NOTA_DO,  5'd4};
                1:       entry = {NOTA_DO,  5'd4};
                2:       entry = {NOTA_SOL, 5'd4};
                3:       entry = {NOTA_SOL, 5'd4};
                4:       entry = {NOTA_LA,  5'd4};
                5:       entry = {NOTA_LA,  5'd4};
                6:       entry = {NOTA_SOL, 5'd8};
                7:       entry = {NOTA_FA,  5'd4};
                8:       entry = {NOTA_FA,  5'd4};
                9:       entry = {NOTA_MI,  5'd4};
                10:      entry = {NOTA_MI,  5'd4};
                11:      entry = {NOTA_RE,  5'd4};
                12:      entry = {NOTA_RE,  5'd4};
                13:      entry = {NOTA_DO,  5'd8};
                14:      entry = {NOTA_SIL, 5'd8};
                default: entry = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/secuenciador_melodia.sv
// Autonomous melody player: walks the song table and drives a one-hot key
// vector as if the keys were held, with a silent gap after every note.
//   clk, rst_n          : system clock, async active-low reset
//   play, stop, loop_en : start (IDLE only), abort (highest priority), loop at end
//   teclas              : one-hot note select (0 = silence), registered
//   busy, done, addr    : activity flag, end-of-song pulse, current table index
//
// state | meaning
// IDLE  | silent, waiting for play
// FETCH | one cycle: read/latch entry at addr, decide play vs. end of song
// PLAY  | key held for dur ticks
// GAP   | silent articulation for GAP_TICKS ticks
// DONE  | one-cycle done pulse, back to IDLE
module secuenciador_melodia
    import secuenciador_melodia_pkg::*;
#(
    parameter int                          CLK_FREQ     = 50_000_000,
    parameter int                          TEMPO_HZ     = 16,
    parameter int                          SONG_LEN     = 32,
    parameter int                          ADDR_W       = 5,
    parameter int                          GAP_TICKS    = 1,
    parameter bit                          USE_CUSTOM   = 1'b0,
    parameter logic [SONG_LEN*ENTRY_W-1:0] CUSTOM_TABLE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              stop,
    input  logic              loop_en,
    output logic [KEYS_W-1:0] teclas,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);

    localparam int                TICK_DIV   = CLK_FREQ / TEMPO_HZ;
    localparam int                PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(SONG_LEN - 1);

    estado_t              state, state_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [ENTRY_W-1:0]   rom_entry, entry_q;
    logic [PRESC_W-1:0]   presc;
    logic [DUR_W-1:0]     ticks, tick_lim;
    logic                 clr_cnt, last_tick, advance;
    logic [KEYS_W-1:0]    teclas_d;
    logic                 busy_d, done_d;

    secuenciador_melodia_rom #(
        .SONG_LEN    (SONG_LEN),
        .ADDR_W      (ADDR_W),
        .USE_CUSTOM  (USE_CUSTOM),
        .CUSTOM_TABLE(CUSTOM_TABLE)
    ) u_rom (
        .addr (addr),
        .entry(rom_entry)
    );

    // Counters restart at every PLAY/GAP entry, so the segment ends on the
    // last prescaler cycle of its final tick.
    always_comb begin
        tick_lim  = (state == ST_PLAY) ? entry_dur(entry_q) : DUR_W'(GAP_TICKS);
        last_tick = (presc == PRESC_LAST) && (ticks == tick_lim - 5'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            addr    <= '0;
            entry_q <= '0;
            presc   <= '0;
            ticks   <= '0;
            teclas  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state  <= state_d;
            addr   <= addr_d;
            teclas <= teclas_d;
            busy   <= busy_d;
            done   <= done_d;
            if (state == ST_FETCH)
                entry_q <= rom_entry;
            if (clr_cnt) begin
                presc <= '0;
                ticks <= '0;
            end else if (presc == PRESC_LAST) begin
                presc <= '0;
                ticks <= ticks + 5'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        addr_d  = addr;
        clr_cnt = 1'b0;
        advance = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (play) begin
                        state_d = ST_FETCH;
                        addr_d  = '0;
                    end
                end
                ST_FETCH: begin
                    if (entry_dur(rom_entry) != '0) begin
                        state_d = ST_PLAY;
                        clr_cnt = 1'b1;
                    end else if (loop_en && addr != '0) begin
                        addr_d = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_PLAY: begin
                    if (last_tick) begin
                        if (GAP_TICKS > 0) begin
                            state_d = ST_GAP;
                            clr_cnt = 1'b1;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (last_tick)
                        advance = 1'b1;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
            // The last table slot behaves like an end marker.
            if (advance) begin
                if (addr == ADDR_LAST) begin
                    if (loop_en) begin
                        addr_d  = '0;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    addr_d  = addr + 1'b1;
                    state_d = ST_FETCH;
                end
            end
        end
    end

    // Outputs are decoded from the next state and registered, so teclas only
    // changes on state boundaries. On FETCH->PLAY the entry is not latched yet.
    always_comb begin
        teclas_d = '0;
        if (state_d == ST_PLAY)
            teclas_d = nota_a_teclas(entry_nota((state == ST_FETCH) ? rom_entry : entry_q));
        busy_d = (state_d == ST_FETCH) || (state_d == ST_PLAY) || (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);
    end

endmodule

// File: tb/tb_secuenciador_melodia.sv
module tb_secuenciador_melodia;

    localparam int NI  = 4;
    localparam int TD  = 10;     // 1000 Hz / 100 Hz
    localparam int GAP = 1;
    localparam int CAP = 1200;

    function automatic logic [255:0] full_tab();
        logic [255:0] t;
        t = '0;
        for (int i = 0; i < 32; i++)
            t[i*8 +: 8] = {3'(i % 8), 5'd1};
        return t;
    endfunction

    // 0: {DO,2},{MI,1},end   1: {SIL,3},{RE,1},{FA,2},{LA,1},end
    // 2: empty               3: 32 one-tick entries, no end marker
    localparam logic [255:0] TAB [NI] = '{256'h006122, 256'hC1824103, 256'h0, full_tab()};

    typedef struct {
        bit         is_end;
        logic [6:0] val;
        logic [4:0] addr;
        int         len;
        bit         done;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       play    [NI];
    logic       stop    [NI];
    logic       loop_en [NI];
    logic [6:0] teclas  [NI];
    logic       busy    [NI];
    logic       done    [NI];
    logic [4:0] addr    [NI];

    item_t sb_q [NI][$];
    int    compared   = 0;
    int    mismatched = 0;

    logic [6:0] tl_v [$];
    logic [4:0] tl_a [$];
    bit         tl_fin;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        secuenciador_melodia #(
            .CLK_FREQ    (1000),
            .TEMPO_HZ    (100),
            .SONG_LEN    (32),
            .ADDR_W      (5),
            .GAP_TICKS   (GAP),
            .USE_CUSTOM  (1'b1),
            .CUSTOM_TABLE(TAB[g])
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .play   (play[g]),
            .stop   (stop[g]),
            .loop_en(loop_en[g]),
            .teclas (teclas[g]),
            .busy   (busy[g]),
            .done   (done[g]),
            .addr   (addr[g])
        );

        logic [6:0] cur_v;
        logic [4:0] cur_a;
        int         cur_len;
        bit         in_busy = 1'b0;

        task automatic close_run(input logic [6:0] v, input logic [4:0] a, input int n);
            item_t it;
            compared++;
            if (sb_q[g].size() == 0) begin
                mismatched++;
                $display("FAIL run_unexpected dut%0d: got teclas=%h addr=%0d len=%0d, required no run", g, v, a, n);
            end else begin
                it = sb_q[g].pop_front();
                if (it.is_end || it.val != v || it.addr != a || it.len != n) begin
                    mismatched++;
                    $display("FAIL run dut%0d: got teclas=%h addr=%0d len=%0d, required teclas=%h addr=%0d len=%0d end=%0d",
                             g, v, a, n, it.val, it.addr, it.len, it.is_end);
                end
            end
        endtask

        always @(negedge clk) begin
            if (!rst_n) begin
                in_busy = 1'b0;
                cur_len = 0;
            end else if (busy[g]) begin
                compared++;
                if (done[g] !== 1'b0) begin
                    mismatched++;
                    $display("FAIL done_while_busy dut%0d: got done=%b, required 0", g, done[g]);
                end
                if (in_busy && teclas[g] === cur_v && addr[g] === cur_a) begin
                    cur_len++;
                end else begin
                    if (in_busy) close_run(cur_v, cur_a, cur_len);
                    cur_v   = teclas[g];
                    cur_a   = addr[g];
                    cur_len = 1;
                    in_busy = 1'b1;
                end
            end else begin
                compared++;
                if (teclas[g] !== 7'h00) begin
                    mismatched++;
                    $display("FAIL idle_teclas dut%0d: got %h, required 00", g, teclas[g]);
                end
                if (in_busy) begin
                    item_t it;
                    close_run(cur_v, cur_a, cur_len);
                    in_busy = 1'b0;
                    compared++;
                    if (sb_q[g].size() == 0) begin
                        mismatched++;
                        $display("FAIL end_unexpected dut%0d: got done=%b addr=%0d, required no end", g, done[g], addr[g]);
                    end else begin
                        it = sb_q[g].pop_front();
                        if (!it.is_end || done[g] !== it.done || addr[g] !== it.addr) begin
                            mismatched++;
                            $display("FAIL end dut%0d: got done=%b addr=%0d, required done=%0d addr=%0d end=%0d",
                                     g, done[g], addr[g], it.done, it.addr, it.is_end);
                        end
                    end
                end else begin
                    compared++;
                    if (done[g] !== 1'b0) begin
                        mismatched++;
                        $display("FAIL done_spurious dut%0d: got done=%b, required 0", g, done[g]);
                    end
                end
            end
        end
    end

    // Reference: cycle-by-cycle (teclas, addr) while busy, starting the cycle
    // after play is sampled. Each entry costs 1 fetch cycle + dur*TD + GAP*TD.
    task automatic build_timeline(input int g, input bit lp);
        int         a;
        logic [7:0] e;
        logic [6:0] v;
        tl_v.delete();
        tl_a.delete();
        tl_fin = 1'b0;
        a = 0;
        while (tl_v.size() < CAP) begin
            tl_v.push_back(7'h00);
            tl_a.push_back(5'(a));
            e = TAB[g][a*8 +: 8];
            if (e[4:0] == 5'd0) begin
                if (lp && a != 0) begin
                    a = 0;
                    continue;
                end
                tl_fin = 1'b1;
                break;
            end
            v = (e[7:5] == 3'd0) ? 7'h00 : 7'(1 << (int'(e[7:5]) - 1));
            for (int k = 0; k < int'(e[4:0]) * TD; k++) begin
                tl_v.push_back(v);
                tl_a.push_back(5'(a));
            end
            for (int k = 0; k < GAP * TD; k++) begin
                tl_v.push_back(7'h00);
                tl_a.push_back(5'(a));
            end
            if (a == 31) begin
                if (lp) begin
                    a = 0;
                    continue;
                end
                tl_fin = 1'b1;
                break;
            end
            a++;
        end
    endtask

    task automatic push_expected(input int g, input int n, input bit dn);
        item_t it;
        int    s;
        s = 0;
        for (int i = 1; i <= n; i++) begin
            if (i == n || tl_v[i] !== tl_v[s] || tl_a[i] !== tl_a[s]) begin
                it = '{is_end: 1'b0, val: tl_v[s], addr: tl_a[s], len: i - s, done: 1'b0};
                sb_q[g].push_back(it);
                s = i;
            end
        end
        it = '{is_end: 1'b1, val: 7'h00, addr: tl_a[n-1], len: 0, done: dn};
        sb_q[g].push_back(it);
    endtask

    // stop_req: 0 = none, >0 = stop sampled at end of that busy cycle, -1 = random.
    task automatic run_song(input int g, input bit lp, input int stop_req, input bit noise);
        int n, stop_at;
        bit aborted;
        build_timeline(g, lp);
        n = tl_v.size();
        stop_at = stop_req;
        if (stop_at < 0)
            stop_at = (!tl_fin || $urandom_range(1, 0) == 1) ? $urandom_range((n < 300) ? n : 300, 1) : 0;
        if (!tl_fin && stop_at == 0)
            stop_at = $urandom_range(300, 1);
        aborted = (stop_at > 0) && (stop_at <= n);
        if (aborted) n = stop_at;
        push_expected(g, n, !aborted);

        loop_en[g] = lp;
        @(posedge clk) #1 play[g] = 1'b1;
        @(posedge clk) #1 play[g] = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (aborted && c == stop_at) begin
                stop[g] = 1'b1;
                play[g] = noise && ($urandom_range(1, 0) == 1);
            end else begin
                play[g] = noise && c >= 2 && c < n - 1 && ($urandom_range(15, 0) == 0);
            end
            @(posedge clk) #1;
            stop[g] = 1'b0;
            play[g] = 1'b0;
        end
        repeat (3) @(posedge clk) #1;
        compared++;
        if (sb_q[g].size() != 0) begin
            mismatched++;
            $display("FAIL drain dut%0d: got %0d pending items, required 0", g, sb_q[g].size());
            sb_q[g].delete();
        end
        loop_en[g] = 1'b0;
    endtask

    task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] req);
        compared++;
        if (got !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) begin
            play[g]    = 1'b0;
            stop[g]    = 1'b0;
            loop_en[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            check_val($sformatf("reset_teclas%0d", g), 32'(teclas[g]), 32'h0);
            check_val($sformatf("reset_busy%0d", g),   32'(busy[g]),   32'h0);
            check_val($sformatf("reset_done%0d", g),   32'(done[g]),   32'h0);
            check_val($sformatf("reset_addr%0d", g),   32'(addr[g]),   32'h0);
        end
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk) #1;

        run_song(0, 1'b0, 0,   1'b0);   // DO 20, gap, MI 10, gap, done
        run_song(0, 1'b0, 7,   1'b0);   // stop inside the DO note
        run_song(0, 1'b1, 130, 1'b0);   // looping, aborted after a couple of passes
        run_song(1, 1'b0, 0,   1'b1);   // rest entry, play pulses while busy
        run_song(2, 1'b1, 0,   1'b0);   // empty table with loop_en must still finish
        run_song(3, 1'b0, 0,   1'b0);   // last slot acts as end marker
        run_song(3, 1'b1, 700, 1'b0);   // last slot wraps to 0 when looping
        for (int r = 0; r < 16; r++)
            run_song($urandom_range(NI - 1, 0), 1'(($urandom_range(1, 0))), -1, 1'b1);

        // Asynchronous reset in the middle of a note.
        build_timeline(0, 1'b0);
        push_expected(0, tl_v.size(), 1'b1);
        @(posedge clk) #1 play[0] = 1'b1;
        @(posedge clk) #1 play[0] = 1'b0;
        repeat (7) @(posedge clk) #1;
        check_val("pre_reset_teclas", 32'(teclas[0]), 32'h01);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_reset_teclas", 32'(teclas[0]), 32'h0);
        check_val("async_reset_busy",   32'(busy[0]),   32'h0);
        check_val("async_reset_addr",   32'(addr[0]),   32'h0);
        sb_q[0].delete();
        @(posedge clk) #3 rst_n = 1'b1;
        repeat (2) @(posedge clk) #1;
        run_song(0, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
